// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding with per-operand hold registers for memory stalls,
// plus the load-use / memory-busy stall controller and a saturating stall counter.
module forward_hazard_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LU_BUBBLES     = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rs2_addr,
    input  logic [DATA_WIDTH-1:0]     idex_rs1_data,
    input  logic [DATA_WIDTH-1:0]     idex_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rd_addr,
    input  logic                      idex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_rd_data,
    input  logic                      exmem_reg_write,
    input  logic                      exmem_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_rd_data,
    input  logic                      memwb_reg_write,
    input  logic                      mem_busy,
    input  logic                      flush,
    output logic [DATA_WIDTH-1:0]     fwd_op1,
    output logic [DATA_WIDTH-1:0]     fwd_op2,
    output logic [1:0]                fwd_sel1,
    output logic [1:0]                fwd_sel2,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      bubble_ex,
    output logic [31:0]               stall_cnt
);

    typedef enum logic [1:0] {RUN, LU_WAIT, MEM_WAIT} state_t;

    localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] stall_cnt_reg;
    logic        lu;

    logic [REG_ADDR_WIDTH-1:0] rs_addr [2];
    logic [DATA_WIDTH-1:0]     rs_data [2];

    assign rs_addr[0] = idex_rs1_addr;
    assign rs_addr[1] = idex_rs2_addr;
    assign rs_data[0] = idex_rs1_data;
    assign rs_data[1] = idex_rs2_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic                      exmem_hit, memwb_hit, hold_hit;
            logic [DATA_WIDTH-1:0]     fwd_data;
            logic [1:0]                fwd_src;
            logic                      hold_valid_reg;
            logic [REG_ADDR_WIDTH-1:0] hold_addr_reg;
            logic [DATA_WIDTH-1:0]     hold_data_reg;

            // A load in EX/MEM has no data yet, so it must not forward.
            assign exmem_hit = exmem_reg_write && !exmem_mem_read &&
                               (exmem_rd_addr != '0) && (exmem_rd_addr == rs_addr[gi]);
            assign memwb_hit = memwb_reg_write &&
                               (memwb_rd_addr != '0) && (memwb_rd_addr == rs_addr[gi]);
            assign hold_hit  = hold_valid_reg && (rs_addr[gi] != '0) &&
                               (hold_addr_reg == rs_addr[gi]);

            always_comb begin
                fwd_data = rs_data[gi];
                fwd_src  = 2'd0;
                if (exmem_hit) begin
                    fwd_data = exmem_rd_data;
                    fwd_src  = 2'd1;
                end else if (memwb_hit) begin
                    fwd_data = memwb_rd_data;
                    fwd_src  = 2'd2;
                end else if (hold_hit) begin
                    fwd_data = hold_data_reg;
                    fwd_src  = 2'd3;
                end
            end

            // MEM/WB retires while EX is frozen; keep its value until EX advances.
            // Flush only acts with mem_busy low, where stall_ex is also low.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    hold_valid_reg <= 1'b0;
                    hold_addr_reg  <= '0;
                    hold_data_reg  <= '0;
                end else if (mem_busy && (fwd_src == 2'd2)) begin
                    hold_valid_reg <= 1'b1;
                    hold_addr_reg  <= rs_addr[gi];
                    hold_data_reg  <= memwb_rd_data;
                end else if (!stall_ex) begin
                    hold_valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    assign fwd_op1  = g_opnd[0].fwd_data;
    assign fwd_sel1 = g_opnd[0].fwd_src;
    assign fwd_op2  = g_opnd[1].fwd_data;
    assign fwd_sel2 = g_opnd[1].fwd_src;

    assign lu = idex_mem_read && (idex_rd_addr != '0) &&
                ((idex_rd_addr == id_rs1_addr) || (idex_rd_addr == id_rs2_addr));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        if (mem_busy) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            state_next = MEM_WAIT;
        end else if (flush) begin
            bubble_ex  = 1'b1;
            state_next = RUN;
            cnt_next   = 3'd0;
        end else if ((state_reg == LU_WAIT) || ((state_reg == MEM_WAIT) && (cnt_reg != 3'd0))) begin
            // Pending bubbles resume immediately after a memory stall.
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            bubble_ex  = 1'b1;
            cnt_next   = cnt_reg - 3'd1;
            state_next = (cnt_reg == 3'd1) ? RUN : LU_WAIT;
        end else begin
            state_next = RUN;
            if (lu) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                bubble_ex  = 1'b1;
                cnt_next   = LU_INIT;
                state_next = (LU_BUBBLES > 1) ? LU_WAIT : RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= RUN;
            cnt_reg       <= 3'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (stall_id && (stall_cnt_reg != 32'hFFFF_FFFF))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all register data ports.
REQ-002 Parameter REG_ADDR_WIDTH, default 5: width of all register-address ports.
REQ-003 Parameter LU_BUBBLES, default 1, legal 1..7: number of bubble cycles inserted per load-use hazard.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 id_rs1_addr, id_rs2_addr  in  REG_ADDR_WIDTH each  source registers of the instruction in ID.
REQ-008 idex_rs1_addr, idex_rs2_addr  in  REG_ADDR_WIDTH each  source registers of the instruction in EX.
REQ-009 idex_rs1_data, idex_rs2_data  in  DATA_WIDTH each  register-file values latched in ID/EX.
REQ-010 idex_rd_addr  in  REG_ADDR_WIDTH, and idex_mem_read  in  1  destination and load flag of the instruction in EX.
REQ-011 exmem_rd_addr  in  REG_ADDR_WIDTH, exmem_rd_data  in  DATA_WIDTH, exmem_reg_write  in  1, exmem_mem_read  in  1  EX/MEM writeback info.
REQ-012 memwb_rd_addr  in  REG_ADDR_WIDTH, memwb_rd_data  in  DATA_WIDTH, memwb_reg_write  in  1  MEM/WB writeback info.
REQ-013 mem_busy  in  1  memory stage not complete this cycle; flush  in  1  branch/exception squash of IF/ID.
REQ-014 fwd_op1, fwd_op2  out  DATA_WIDTH each  resolved EX operands.
REQ-015 fwd_sel1, fwd_sel2  out  2 each  source: 0 ID/EX, 1 EX/MEM, 2 MEM/WB, 3 hold register.
REQ-016 stall_if, stall_id, stall_ex  out  1 each  hold the named pipeline register; bubble_ex  out  1  load NOP into ID/EX.
REQ-017 stall_cnt  out  32  saturating count of cycles with stall_id=1.

Function
REQ-018 Operand k resolution (combinational), priority order: (a) exmem_reg_write, exmem_rd_addr!=0, exmem_rd_addr==idex_rsk_addr, exmem_mem_read=0 -> exmem_rd_data, sel 1; (b) memwb_reg_write, memwb_rd_addr!=0, address match -> memwb_rd_data, sel 2; (c) hold_valid_k and hold_addr_k==idex_rsk_addr -> hold_data_k, sel 3; (d) else idex_rsk_data, sel 0.
REQ-019 Address 0 never matches any forwarding source; operand k with idex_rsk_addr=0 always selects sel 0.
REQ-020 Hold register k: while mem_busy=1 and case (b) is selected for operand k, capture memwb_rd_data, hold_addr_k=idex_rsk_addr, hold_valid_k=1 at the next edge; an existing valid hold is overwritten only by a newer (b) match.
REQ-021 hold_valid_k clears at the edge of any cycle with stall_ex=0 (EX advances), and on flush or reset.
REQ-022 Load-use hazard LU = idex_mem_read and idex_rd_addr!=0 and (idex_rd_addr==id_rs1_addr or idex_rd_addr==id_rs2_addr).
REQ-023 FSM states RUN, LU_WAIT, MEM_WAIT; 3-bit bubble counter cnt.
REQ-024 RUN, mem_busy=0, LU=1: outputs stall_if=stall_id=bubble_ex=1, stall_ex=0; next state LU_WAIT with cnt=LU_BUBBLES-1 if LU_BUBBLES>1, else RUN.
REQ-025 LU_WAIT, mem_busy=0: outputs stall_if=stall_id=bubble_ex=1; cnt decrements; exit to RUN on the edge where cnt==1.
REQ-026 Any state, mem_busy=1: stall_if=stall_id=stall_ex=1, bubble_ex=0, cnt frozen, next state MEM_WAIT; mem_busy has priority over LU and flush.
REQ-027 MEM_WAIT, mem_busy=0: behaves as LU_WAIT if cnt>0, else as RUN, in the same cycle (no extra dead cycle).
REQ-028 flush=1 with mem_busy=0: bubble_ex=1, all stall_* =0, next state RUN, cnt=0, holds cleared; LU ignored that cycle.
REQ-029 RUN with no hazard, no mem_busy, no flush: all stall_* and bubble_ex =0.
REQ-030 stall_cnt increments by 1 at each edge where stall_id=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-031 rst_i=1 at an edge: state=RUN, cnt=0, hold_valid_k=0, hold_data_k=0, hold_addr_k=0, stall_cnt=0; combinational outputs then follow REQ-018..029 with this state.

Verification
REQ-032 idex_rs1_addr=5, exmem rd=5 data 0xAAAA_0001 rw=1, memwb rd=5 data 0xBBBB_0002 rw=1 -> fwd_op1=0xAAAA_0001, fwd_sel1=1; set exmem_mem_read=1 -> fwd_op1=0xBBBB_0002, sel 2.
REQ-033 idex_rs2_addr=0, exmem rd=0 rw=1, idex_rs2_data=0x1234 -> fwd_op2=0x1234, fwd_sel2=0.
REQ-034 LU_BUBBLES=1, load rd=7 in EX, id_rs2_addr=7 -> stall_if/stall_id/bubble_ex =1 for exactly 1 cycle, stall_cnt=1; LU_BUBBLES=3 -> 3 cycles, stall_cnt=3.
REQ-035 memwb rd=9 data 0xCAFE_F00D matches idex_rs1_addr=9, mem_busy=1 for 4 cycles with memwb_reg_write dropping after cycle 1 -> fwd_op1=0xCAFE_F00D, sel 3 for cycles 2..4 and the release cycle; hold cleared after release.
REQ-036 mem_busy asserted mid LU_WAIT (LU_BUBBLES=3, after 1 bubble) for 2 cycles -> 2 stall cycles with bubble_ex=0, then remaining 2 bubble cycles; stall_cnt=5.
REQ-037 flush=1 during LU_WAIT -> bubble_ex=1, stalls 0 that cycle, RUN next; rst_i mid MEM_WAIT -> RUN, stall_cnt=0, holds invalid.
